// File: rtl/tow_referee.sv
`default_nettype none
// ============================================================================
//  Module   : tow_referee
//  Purpose  : Tug-of-War referee. Samples push/tie/right decisions, moves the
//             one-hot rope position, declares a winner and drives clr back to
//             the push-button latches. A release window of REL_CYCLES
//             consecutive idle cycles re-arms the referee, so that one press
//             equals exactly one move.
//  Revision : 1.0  initial release
// ============================================================================
module tow_referee #(
   parameter int LEDS       = 7,
   parameter int REL_CYCLES = 16,
   parameter int REL_W      = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            tie,
   input  logic            right,
   output logic            clr,
   output logic            ready,
   output logic [LEDS-1:0] leds,
   output logic            left_win,
   output logic            right_win
);

   localparam int              PW       = $clog2(LEDS);
   localparam logic [PW-1:0]   CTR      = PW'((LEDS - 1) / 2);
   localparam logic [PW-1:0]   POS_MAX  = PW'(LEDS - 1);
   localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_CYCLES - 1);
   localparam logic [LEDS-1:0] LEDS_CTR = LEDS'(1) << CTR;

   localparam logic [1:0] ST_ARM   = 2'd0;
   localparam logic [1:0] ST_READY = 2'd1;
   localparam logic [1:0] ST_WIN   = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic [PW-1:0]    pos_q,       pos_d;
   logic [REL_W-1:0] rel_cnt_q,   rel_cnt_d;
   logic             left_win_q,  left_win_d;
   logic             right_win_q, right_win_d;
   logic             clr_q,       clr_d;
   logic             ready_q,     ready_d;
   logic [LEDS-1:0]  leds_q,      leds_d;

   // State and output registers; reset returns to the armed centre position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ARM;
         pos_q       <= CTR;
         rel_cnt_q   <= '0;
         left_win_q  <= 1'b0;
         right_win_q <= 1'b0;
         clr_q       <= 1'b1;
         ready_q     <= 1'b0;
         leds_q      <= LEDS_CTR;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         rel_cnt_q   <= rel_cnt_d;
         left_win_q  <= left_win_d;
         right_win_q <= right_win_d;
         clr_q       <= clr_d;
         ready_q     <= ready_d;
         leds_q      <= leds_d;
      end
   end

   // Next-state: release qualification in ARM, single move per READY entry.
   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      rel_cnt_d   = rel_cnt_q;
      left_win_d  = left_win_q;
      right_win_d = right_win_q;
      case (state_q)
         ST_ARM: begin
            if (push) begin
               // Any bounce inside the window restarts the count.
               rel_cnt_d = '0;
            end else if (rel_cnt_q == REL_LAST) begin
               rel_cnt_d = '0;
               state_d   = ST_READY;
            end else begin
               rel_cnt_d = rel_cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (push) begin
               // tie outranks right; neither means the left player won.
               if (tie) begin
                  pos_d = pos_q;
               end else if (right) begin
                  pos_d = pos_q + 1'b1;
               end else begin
                  pos_d = pos_q - 1'b1;
               end
               if (pos_d == POS_MAX) begin
                  right_win_d = 1'b1;
                  state_d     = ST_WIN;
               end else if (pos_d == '0) begin
                  left_win_d = 1'b1;
                  state_d    = ST_WIN;
               end else begin
                  state_d = ST_ARM;
               end
            end
         end
         ST_WIN: begin
            // Game over: everything held until reset.
         end
         default: begin
            // Unused encoding: fall back to re-arming.
            state_d = ST_ARM;
         end
      endcase
   end

   // Output decode from the next state so the outputs are registered.
   always_comb begin
      clr_d   = (state_d != ST_READY);
      ready_d = (state_d == ST_READY);
      leds_d  = LEDS'(1) << pos_d;
   end

   assign clr       = clr_q;
   assign ready     = ready_q;
   assign leds      = leds_q;
   assign left_win  = left_win_q;
   assign right_win = right_win_q;

endmodule
`default_nettype wire

// File: tb/tb_tow_referee.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tow_referee
//  Purpose  : Self-checking bench for tow_referee: table of single presses
//             plus hand-written sequences for hold, bounce, win and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tow_referee;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push = 1'b0;
   logic       tie = 1'b0;
   logic       right = 1'b0;
   logic       clr, ready, left_win, right_win;
   logic [6:0] leds;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       push;
      logic       tie;
      logic       right;
      logic [6:0] leds;
      logic       clr;
      logic       ready;
      logic       lw;
      logic       rw;
   } vec_t;

   vec_t tbl [5];

   tow_referee #(.LEDS(7), .REL_CYCLES(16), .REL_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .tie       (tie),
      .right     (right),
      .clr       (clr),
      .ready     (ready),
      .leds      (leds),
      .left_win  (left_win),
      .right_win (right_win)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // advance one edge and settle 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [6:0] el, input logic ec,
                          input logic er, input logic elw, input logic erw);
      chk({name, ".leds"},  {25'd0, leds}, {25'd0, el});
      chk({name, ".clr"},   {31'd0, clr},  {31'd0, ec});
      chk({name, ".ready"}, {31'd0, ready}, {31'd0, er});
      chk({name, ".lw"},    {31'd0, left_win},  {31'd0, elw});
      chk({name, ".rw"},    {31'd0, right_win}, {31'd0, erw});
   endtask

   // 15 idle edges keep ready low, the 16th raises it
   task automatic arm_wait(input string name);
      push = 1'b0; tie = 1'b0; right = 1'b0;
      repeat (15) step();
      chk({name, ".pre_ready"}, {31'd0, ready}, 32'd0);
      step();
      chk({name, ".ready"}, {31'd0, ready}, 32'd1);
      chk({name, ".clr"},   {31'd0, clr},   32'd0);
   endtask

   task automatic press(input logic t, input logic r);
      push = 1'b1; tie = t; right = r;
      step();
      push = 1'b0; tie = 1'b0; right = 1'b0;
   endtask

   task automatic async_reset(input string name);
      #2 rst = 1'b1;
      #1 chk_all(name, 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b1, 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0}; // tie+right = tie
      tbl[1] = '{1'b0, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b1, 1'b0, 1'b0}; // no push: ignored
      tbl[2] = '{1'b1, 1'b0, 1'b1, 7'b0010000, 1'b1, 1'b0, 1'b0, 1'b0}; // right move
      tbl[3] = '{1'b1, 1'b0, 1'b0, 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0}; // left move
      tbl[4] = '{1'b1, 1'b1, 1'b0, 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0}; // tie only

      // reset and arm
      #2 rst = 1'b1;
      #1 chk_all("reset", 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;
      chk_all("after_rst", 7'b0001000, 1'b1, 1'b0, 1'b0, 1'b0);
      arm_wait("arm0");

      // table of single presses from READY
      for (int i = 0; i < 5; i++) begin
         push = tbl[i].push; tie = tbl[i].tie; right = tbl[i].right;
         step();
         push = 1'b0; tie = 1'b0; right = 1'b0;
         chk_all($sformatf("vec%0d", i), tbl[i].leds, tbl[i].clr, tbl[i].ready,
                 tbl[i].lw, tbl[i].rw);
         if (tbl[i].push) arm_wait($sformatf("vec%0d_arm", i));
      end

      // held button: one left move only
      push = 1'b1; tie = 1'b0; right = 1'b0;
      step();
      chk_all("held_first", 7'b0000100, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (39) step();
      chk_all("held_end", 7'b0000100, 1'b1, 1'b0, 1'b0, 1'b0);
      // bounce at release cycle 10 restarts the window
      push = 1'b0;
      repeat (10) step();
      push = 1'b1;
      step();
      chk({"bounce.ready"}, {31'd0, ready}, 32'd0);
      arm_wait("bounce");
      chk({"bounce.leds"}, {25'd0, leds}, {25'd0, 7'b0000100});

      // back to centre, then three right presses win
      press(1'b0, 1'b1);
      chk({"recentre"}, {25'd0, leds}, {25'd0, 7'b0001000});
      arm_wait("recentre_arm");
      press(1'b0, 1'b1);
      arm_wait("r1");
      press(1'b0, 1'b1);
      chk({"r2.leds"}, {25'd0, leds}, {25'd0, 7'b0100000});
      arm_wait("r2");
      press(1'b0, 1'b1);
      chk_all("rwin", 7'b1000000, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (20) step();
      press(1'b0, 1'b0);
      repeat (20) step();
      press(1'b0, 1'b1);
      chk_all("rwin_lock", 7'b1000000, 1'b1, 1'b0, 1'b0, 1'b1);

      // async reset from WIN, then left win
      async_reset("rst_win");
      arm_wait("larm0");
      press(1'b0, 1'b0);
      arm_wait("larm1");
      press(1'b0, 1'b0);
      chk({"l2.leds"}, {25'd0, leds}, {25'd0, 7'b0000010});
      arm_wait("larm2");
      press(1'b0, 1'b0);
      chk_all("lwin", 7'b0000001, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (20) step();
      chk_all("lwin_lock", 7'b0000001, 1'b1, 1'b0, 1'b1, 1'b0);

      // async reset mid-ARM after a move
      async_reset("rst_lwin");
      arm_wait("marm");
      press(1'b0, 1'b1);
      repeat (5) step();
      chk({"mid.leds"}, {25'd0, leds}, {25'd0, 7'b0010000});
      async_reset("rst_arm");
      arm_wait("final_arm");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tow_referee.md
Name: tow_referee

Overview:
- Consumer end of the push-button logic interface in the Tug-of-War design.
- Samples the push, tie and right decisions, moves the one-hot rope LED position, and declares a winner.
- Drives clr back to the push-button logic to clear its first-press latches.
- Enforces a release-qualification window so that one press equals exactly one move.

Parameters:
- LEDS, 7: rope length in LEDs. Must be odd and >= 3. Centre index CTR = (LEDS-1)/2.
- REL_CYCLES, 16: consecutive cycles with push low required before re-arming. Must be >= 1.
- REL_W, 5: width of the release counter. Must hold REL_CYCLES-1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  some button pressed, from push-button logic.
- tie  in  1  both buttons pressed simultaneously.
- right  in  1  right player won the press race.
- clr  out  1  registered; clears the push-button latches; high while not accepting a press.
- ready  out  1  registered; high only in state READY.
- leds  out  LEDS  one-hot rope position; bit 0 = left end, bit LEDS-1 = right end.
- left_win  out  1  registered, sticky; left player won.
- right_win  out  1  registered, sticky; right player won.

Behaviour:
Reset:
- rst=1 forces immediately, with no clock edge needed: state=ARM, pos=CTR, leds=one-hot(CTR), rel_cnt=0, clr=1, ready=0, left_win=0, right_win=0.
- Reset mid-operation (any state, including WIN) aborts and returns to these values.

State register: ARM, READY, WIN.

ARM (clr=1, ready=0):
- On each edge: push=1 → rel_cnt<=0; push=0 → rel_cnt<=rel_cnt+1.
- On the edge where push=0 and rel_cnt==REL_CYCLES-1: rel_cnt<=0 and state<=READY. This takes REL_CYCLES consecutive low cycles.
- Any push=1 inside the window (glitch or bounce) restarts the count.

READY (clr=0, ready=1):
- On an edge with push=0: no change.
- On an edge with push=1, exactly one move, decoded with this priority:
  - tie=1: pos unchanged.
  - else right=1: pos<=pos+1.
  - else: left move, pos<=pos-1.
- Same edge: state<=ARM, so clr=1 and ready=0 are visible the following cycle.
- Latency from push sampled to leds updated: 1 edge.
- If the new pos==LEDS-1: right_win<=1, state<=WIN instead of ARM.
- If the new pos==0: left_win<=1, state<=WIN instead of ARM.

WIN (clr=1, ready=0):
- All inputs ignored; pos, leds and win flags held until rst.

Invariants:
- pos never wraps: moves happen only from READY, and READY is unreachable once pos is at an end.
- leds is always exactly one-hot.
- left_win and right_win are never both 1.
- Only one move per READY entry, even if push is held for many cycles.

Simultaneous events:
- tie=1 together with right=1 is treated as a tie.
- push=0 with tie=1 or right=1 is ignored; push gates everything.

Widths:
- pos is $clog2(LEDS) bits.
- rel_cnt is REL_W bits and never exceeds REL_CYCLES-1.

Test Plan:
1. Reset and arm: assert rst, hold push=0, release rst. Required: leds=7'b0001000, clr=1, ready=0. After 16 edges: ready=1, clr=0.
2. Right move: in READY, push=1 and right=1 for one cycle. Required: next cycle leds=7'b0010000, clr=1, ready=0. Hold push=0 for 16 cycles: ready=1.
3. Held and bouncing button: in READY, push held 40 cycles with right=0. Required: single left move, leds=7'b0000100. In ARM, pulse push=1 at release cycle 10. Required: ready does not rise until 16 clean cycles after the pulse.
4. Tie: in READY, push=1, tie=1, right=1. Required: leds unchanged at 7'b0001000, state returns to ARM, no win flags.
5. Win and lockout: three right presses from centre, each separated by the release window. Required: leds=7'b1000000, right_win=1, left_win=0, clr=1 held. Further presses change nothing.
6. Async reset mid-ARM and from WIN: assert rst between clock edges. Required: leds=7'b0001000, win flags=0, clr=1 immediately, before the next edge.
